// File: rtl/greater_seq.sv
// rtl/greater_seq.sv - multi-cycle MSB-first magnitude comparator, CHUNK bits per clock
// Selectable relation (>, >=, ==, <) and signed/unsigned operands with start/busy/valid handshake.
module greater_seq #(
  parameter int NUM   = 8,
  parameter int CHUNK = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [NUM-1:0] i_argA,
  input  logic [NUM-1:0] i_argB,
  input  logic [1:0]     i_mode,
  input  logic           i_signed,
  output logic           o_busy,
  output logic           o_valid,
  output logic           o_result,
  output logic           o_gt,
  output logic           o_eq
);
  localparam int N  = NUM / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [NUM-1:0]   r_a;
  logic [NUM-1:0]   r_b;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_mode;
  logic             r_decided;
  logic             r_gt_flag;
  logic             r_gt;
  logic             r_eq;
  logic             r_result;

  logic [NUM-1:0]   w_flip;
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic             w_decided;
  logic             w_gt_flag;
  logic             w_fin_gt;
  logic             w_fin_eq;
  logic             w_fin_result;

  // Inverting the sign bit maps two's complement onto offset binary.
  assign w_flip = {i_signed, {(NUM-1){1'b0}}};

  always_comb begin
    w_chunk_a = r_a[NUM-1 -: CHUNK];
    w_chunk_b = r_b[NUM-1 -: CHUNK];
    w_decided = r_decided;
    w_gt_flag = r_gt_flag;
    if (!r_decided && (w_chunk_a != w_chunk_b)) begin
      w_decided = 1'b1;
      w_gt_flag = (w_chunk_a > w_chunk_b);
    end
    w_fin_eq = ~w_decided;
    w_fin_gt = w_decided & w_gt_flag;
    case (r_mode)
      2'b00:   w_fin_result = w_fin_gt;
      2'b01:   w_fin_result = w_fin_gt | w_fin_eq;
      2'b10:   w_fin_result = w_fin_eq;
      default: w_fin_result = ~(w_fin_gt | w_fin_eq);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Results are captured on the last BUSY edge so they are visible during DONE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_decided <= 1'b0;
      r_gt_flag <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_result  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a       <= i_argA ^ w_flip;
          r_b       <= i_argB ^ w_flip;
          r_mode    <= i_mode;
          r_cnt     <= CNT_LOAD;
          r_decided <= 1'b0;
          r_gt_flag <= 1'b0;
        end
        S_BUSY: begin
          r_a       <= r_a << CHUNK;
          r_b       <= r_b << CHUNK;
          r_decided <= w_decided;
          r_gt_flag <= w_gt_flag;
          if (r_cnt == '0) begin
            r_gt     <= w_fin_gt;
            r_eq     <= w_fin_eq;
            r_result <= w_fin_result;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_gt     = r_gt;
  assign o_eq     = r_eq;
endmodule

// File: tb/tb_greater_seq.sv
// tb/tb_greater_seq.sv - randomized self-checking bench for greater_seq
// Four parameterisations run side by side against an integer reference model.
module tb_greater_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        sgn = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
  logic [3:0]  busy, valid, res, gt, eq;

  localparam int NW [4] = '{8, 4, 4, 16};
  localparam int NN [4] = '{4, 1, 4, 4};

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  greater_seq #(.NUM(8), .CHUNK(2)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_argA(opa[7:0]), .i_argB(opb[7:0]),
    .i_mode(mode), .i_signed(sgn), .o_busy(busy[0]), .o_valid(valid[0]),
    .o_result(res[0]), .o_gt(gt[0]), .o_eq(eq[0]));
  greater_seq #(.NUM(4), .CHUNK(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_argA(opa[3:0]), .i_argB(opb[3:0]),
    .i_mode(mode), .i_signed(sgn), .o_busy(busy[1]), .o_valid(valid[1]),
    .o_result(res[1]), .o_gt(gt[1]), .o_eq(eq[1]));
  greater_seq #(.NUM(4), .CHUNK(1)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_argA(opa[3:0]), .i_argB(opb[3:0]),
    .i_mode(mode), .i_signed(sgn), .o_busy(busy[2]), .o_valid(valid[2]),
    .o_result(res[2]), .o_gt(gt[2]), .o_eq(eq[2]));
  greater_seq #(.NUM(16), .CHUNK(4)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_argA(opa), .i_argB(opb),
    .i_mode(mode), .i_signed(sgn), .o_busy(busy[3]), .o_valid(valid[3]),
    .o_result(res[3]), .o_gt(gt[3]), .o_eq(eq[3]));

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns {result, gt, eq} from the operands' integer values.
  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b,
                                       input int w, input logic [1:0] m, input logic s);
    longint va, vb, msk;
    logic g, e, r;
    msk = (longint'(1) << w) - 1;
    va = longint'(a) & msk;
    vb = longint'(b) & msk;
    if (s && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (s && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    g = (va > vb);
    e = (va == vb);
    case (m)
      2'b00:   r = g;
      2'b01:   r = g | e;
      2'b10:   r = e;
      default: r = (va < vb);
    endcase
    return {r, g, e};
  endfunction

  // One compare on all four instances; latency counted in edges after the accepting edge.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                     input logic s, input string tag);
    int lat [4];
    int nv [4];
    logic [2:0] got [4];
    logic [2:0] exp;
    int busy_cyc;
    opa = a; opb = b; mode = m; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = ~a; opb = ~b; mode = ~m; sgn = ~s;
    busy_cyc = busy[0] ? 1 : 0;
    for (int i = 0; i < 4; i++) begin lat[i] = -1; nv[i] = 0; got[i] = '0; end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (busy[0]) busy_cyc++;
      for (int i = 0; i < 4; i++) begin
        if (valid[i]) begin
          nv[i]++;
          if (lat[i] < 0) begin
            lat[i] = c;
            got[i] = {res[i], gt[i], eq[i]};
          end
        end
      end
    end
    check({tag, "_busy0"}, busy_cyc, NN[0] + 1);
    for (int i = 0; i < 4; i++) begin
      exp = model(a, b, NW[i], m, s);
      check($sformatf("%s_lat%0d", tag, i), lat[i], NN[i]);
      check($sformatf("%s_nv%0d", tag, i), nv[i], 1);
      check($sformatf("%s_res%0d", tag, i), got[i][2], exp[2]);
      check($sformatf("%s_gt%0d", tag, i), got[i][1], exp[1]);
      check($sformatf("%s_eq%0d", tag, i), got[i][0], exp[0]);
    end
  endtask

  initial begin
    int vcyc [$];
    int nval;
    logic [15:0] ra, rb;

    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_res", {res, gt, eq}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(16'd6, 16'd2, 2'b00, 1'b0, "gt62");
    check("gt62_holdres", res[0], 1);
    run(16'd1, 16'd1, 2'b00, 1'b0, "eq_m0");
    run(16'd1, 16'd1, 2'b01, 1'b0, "eq_m1");
    run(16'd1, 16'd1, 2'b10, 1'b0, "eq_m2");
    run(16'h00FD, 16'h0002, 2'b11, 1'b1, "neg3");
    run(16'h00FD, 16'h0002, 2'b11, 1'b0, "u253");
    run(16'h0080, 16'h007F, 2'b00, 1'b1, "s80");
    run(16'h0003, 16'h0002, 2'b00, 1'b0, "lastchunk");
    run(16'h0080, 16'h007F, 2'b00, 1'b0, "firstchunk");

    // Stray start during BUSY with different operands must be ignored.
    opa = 16'd6; opb = 16'd2; mode = 2'b00; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    opa = 16'd1; opb = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid[0]) begin
        nval++;
        check("ign_res", res[0], 1);
        check("ign_gt", gt[0], 1);
      end
      @(posedge clk); #1;
    end
    check("ign_nvalid", nval, 1);

    // Held start: consecutive valid pulses N+2 cycles apart.
    opa = 16'd5; opb = 16'd3; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid[0]) vcyc.push_back(c);
    end
    start = 1'b0;
    check("held_count", vcyc.size() >= 4, 1);
    for (int i = 1; i < vcyc.size(); i++) check($sformatf("held_gap%0d", i), vcyc[i] - vcyc[i-1], NN[0] + 2);
    repeat (10) @(posedge clk);
    #1;

    // Abort at BUSY cycle 2 after a result of 1 is held.
    run(16'd9, 16'd4, 2'b00, 1'b0, "preabort");
    opa = 16'd1; opb = 16'd1; mode = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy[0], 0);
    check("abort_valid", valid[0], 0);
    check("abort_res", {res[0], gt[0], eq[0]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nval = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (valid != 0) nval++;
    end
    check("abort_novalid", nval, 0);
    run(16'h00FE, 16'h00FF, 2'b11, 1'b0, "postabort");

    // Random sweep per mode and signedness.
    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 200; k++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          if ($urandom_range(0, 3) == 0) rb = ra;
          else if ($urandom_range(0, 3) == 0) rb = ra ^ 16'(1 << $urandom_range(0, 15));
          run(ra, rb, 2'(m), 1'(s), $sformatf("rnd_m%0d_s%0d", m, s));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
